// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared types and constants for the AND-gate sweep controller
package gate_sweep_pkg;

  localparam int VEC_W   = 3;
  localparam int VEC_CNT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/sweep_vec_enc.sv
// rtl/sweep_vec_enc.sv - sweep index to {x,y,w} vector encoder
// Define SWEEP_GRAY_EN for Gray-code ordering; default ordering is binary.
module sweep_vec_enc
  import gate_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] idx_i,
  output logic [VEC_W-1:0] vec_o
);

`ifdef SWEEP_GRAY_EN
  // Only one gate input toggles between consecutive vectors.
  assign vec_o = idx_i ^ (idx_i >> 1);
`else
  assign vec_o = idx_i;
`endif

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - drives all eight input vectors into a 3-input AND gate and scores its response
// Vector ordering is selected in sweep_vec_enc by SWEEP_GRAY_EN.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x,
  output logic       y,
  output logic       w,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail,
  output logic       fail_valid
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] IDX_LAST    = VEC_W'(VEC_CNT - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       err_q, err_d;
  logic             pass_q, pass_d;
  logic [VEC_W-1:0] ff_q, ff_d;
  logic             fv_q, fv_d;
  logic [VEC_W-1:0] vec;
  logic             drive_en;

  sweep_vec_enc u_enc (
    .idx_i (idx_q),
    .vec_o (vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          ff_d    = '0;
          fv_d    = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (z != (&vec)) begin
          err_d = err_q + 4'd1;
          if (!fv_q) begin
            ff_d = vec;
            fv_d = 1'b1;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          // pass must already be valid during the DONE cycle, so use the final count
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign drive_en   = (state_q == SETTLE) || (state_q == SAMPLE);
  assign busy       = drive_en;
  assign done       = (state_q == DONE);
  assign {x, y, w}  = drive_en ? vec : '0;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl
module tb_gate_sweep_ctrl;

  localparam int S   = 2;
  localparam int LAT = 1 + 8 * (S + 1);

  logic       clk = 1'b0;
  logic       rst, start, z;
  logic       x, y, w, busy, done, pass, fail_valid;
  logic [3:0] err_cnt;
  logic [2:0] first_fail;

  int         total = 0;
  int         bad   = 0;
  int         mode;
  logic [7:0] fmask;
  int         order[8];

  typedef struct {
    int         m;
    logic [7:0] mask;
    int         e_err;
    int         e_first;
    bit         e_fv;
  } vec_t;

  vec_t tbl[5];

  gate_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x          (x),
    .y          (y),
    .w          (w),
    .z          (z),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail),
    .fail_valid (fail_valid)
  );

  always #5 clk = ~clk;

  // Gate under sweep: a good AND, stuck-at faults, or an AND with per-vector output flips.
  always_comb begin
    case (mode)
      1:       z = 1'b0;
      2:       z = 1'b1;
      default: z = (x & y & w) ^ fmask[{x, y, w}];
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input int m, input logic [7:0] mk,
                       output int e_err, output int e_first, output bit e_fv);
    e_err = 0; e_first = 0; e_fv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int v;
      bit good, got;
      v    = order[i];
      good = (v == 7);
      got  = (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : (good ^ mk[v]);
      if (got != good) begin
        e_err++;
        if (!e_fv) begin
          e_fv    = 1'b1;
          e_first = v;
        end
      end
    end
  endtask

  task automatic run_sweep(input int e_err, input int e_first, input bit e_fv, input bit repulse);
    int         n_done;
    int         done_cyc;
    logic [2:0] cur, prev;
    int         idx;
    n_done = 0; done_cyc = -1; prev = '0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (repulse && (c == 5 || c == LAT)) start = 1'b1;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c < LAT) begin
        idx = (c - 1) / (S + 1);
        cur = {x, y, w};
        chk("busy_in_sweep", int'(busy), 1);
        chk("vector_order", int'(cur), order[idx]);
`ifdef SWEEP_GRAY_EN
        if (idx > 0 && ((c - 1) % (S + 1)) == 0) chk("gray_one_bit", $countones(cur ^ prev), 1);
`endif
        prev = cur;
      end
      if (c == LAT) begin
        chk("busy_in_done", int'(busy), 0);
        chk("vec_in_done", int'({x, y, w}), 0);
        chk("err_cnt", int'(err_cnt), e_err);
        chk("pass", int'(pass), int'(e_err == 0));
        chk("fail_valid", int'(fail_valid), int'(e_fv));
        if (e_fv) chk("first_fail", int'(first_fail), e_first);
      end
      if (c == LAT + 2) begin
        chk("hold_busy", int'(busy), 0);
        chk("hold_vec", int'({x, y, w}), 0);
        chk("hold_err_cnt", int'(err_cnt), e_err);
        chk("hold_pass", int'(pass), int'(e_err == 0));
        chk("hold_fail_valid", int'(fail_valid), int'(e_fv));
      end
    end
    chk("done_latency", done_cyc, LAT);
    chk("done_pulses", n_done, 1);
  endtask

  initial begin
    int e_err, e_first, n_done;
    bit e_fv;

`ifdef SWEEP_GRAY_EN
    order = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
    for (int i = 0; i < 8; i++) order[i] = i;
`endif
    tbl[0] = '{0, 8'h00, 0, 0, 1'b0};
    tbl[1] = '{1, 8'h00, 1, 7, 1'b1};
    tbl[2] = '{2, 8'h00, 7, 0, 1'b1};
    tbl[3] = '{0, 8'h04, 1, 2, 1'b1};
    tbl[4] = '{0, 8'h81, 2, 0, 1'b1};

    mode = 0; fmask = '0; start = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_vec", int'({x, y, w}), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_first_fail", int'(first_fail), 0);
    chk("rst_fail_valid", int'(fail_valid), 0);
    start = 1'b1;
    @(negedge clk);
    chk("rst_over_start", int'(busy), 0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].m; fmask = tbl[i].mask;
      run_sweep(tbl[i].e_err, tbl[i].e_first, tbl[i].e_fv, 1'b0);
    end

    mode = 0; fmask = 8'h00;
    run_sweep(0, 0, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      mode = 0; fmask = 8'($urandom);
      model(mode, fmask, e_err, e_first, e_fv);
      run_sweep(e_err, e_first, e_fv, 1'b0);
    end

    mode = 2; fmask = '0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_vec", int'({x, y, w}), 0);
    chk("abort_err_cnt", int'(err_cnt), 0);
    chk("abort_fail_valid", int'(fail_valid), 0);
    chk("abort_pass", int'(pass), 0);
    n_done = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    mode = 0;
    run_sweep(0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
